sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the next-generation buffer for intra-domain data paths where the dual-clock FIFO's gray-code synchronisers are unnecessary overhead.
Adds an occupancy count, programmable almost-full and almost-empty flags, overflow and underflow pulses, and full-pass-through on simultaneous read and write.
Sits between producer and consumer logic inside one clock domain.

Parameters:
- DATA_WIDTH, 8, width of data_in and data_out.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, not overridden.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write requested but rejected.
- underflow  out  1  one-cycle pulse: read requested but rejected.

Behaviour:
- Reset: while rst_n is sampled low at a clk edge, the following hold:
  - wr_ptr, rd_ptr and count are 0; data_out is 0; overflow and underflow are 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored entries on that edge.
- Acceptance is evaluated on pre-edge state:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc). A write when full is accepted only if a read is accepted in the same cycle.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments modulo DEPTH (natural wrap; ADDR_WIDTH bits).
- Read (default mode):
  - On rd_acc, data_out <= mem[rd_ptr] and rd_ptr increments modulo DEPTH. Latency is 1 cycle from the rd_en edge.
  - Without rd_acc, data_out holds its value.
- Count: count <= count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Empty plus simultaneous wr_en and rd_en: the write is accepted, the read is rejected, underflow pulses and count becomes 1.
- Full plus simultaneous wr_en and rd_en: both are accepted, count stays DEPTH, and no overflow.
- Flags are combinational decodes of the registered count; there are no extra flag latencies.
- overflow <= wr_en && !wr_acc; underflow <= rd_en && !rd_acc. Both are registered and high for exactly one cycle per rejected request.
- A write and a read to the same index in one cycle (only possible with count==DEPTH) returns the old stored word.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out continuously shows mem[rd_ptr] whenever !empty.
  - rd_en acts as a pop/acknowledge, with 0-cycle latency to the head word.
  - When empty, data_out shows the last head value; its value is don't-care to consumers.
  - The empty-plus-simultaneous-write case still rejects the read; the new word becomes visible the following cycle.
- Undefined: the registered 1-cycle read described above.
- Acceptance, count, flags and error pulses are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - the default DATA_WIDTH and DEPTH constants;
  - a width helper function for count (ADDR_WIDTH+1);
  - a typedef for the pointer type.
- One sub-module, fifo_mem_2p: a register-array memory with one synchronous write port and one read port.
  - The read port is registered, or combinational under SYNC_FIFO_FWFT_EN.
  - The pointer, count and flag logic stays in the top module.

Test Plan (DATA_WIDTH=8, DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1):
- Reset with rst_n=0 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, data_out=0x00, no pulses.
- Write 0x10..0x17 on 8 consecutive cycles, then one more wr_en -> almost_full rises when count=6; full=1 at count=8; the 9th write gives overflow=1 for one cycle and count stays 8.
- From full, read 8 times -> data_out is 0x10..0x17 in order, each 1 cycle after rd_en; empty=1 after the last read. A further rd_en gives underflow=1 and data_out stays 0x17.
- At full, assert wr_en=1 with data 0xAA together with rd_en=1 -> count stays 8, no overflow, data_out=0x10. After draining, 0xAA is the last word out.
- Interleave writes and reads across 20 entries -> pointer wrap is transparent, data order is preserved, and count matches the reference model every cycle.
- Set rst_n=0 with count=5 -> next edge gives count=0 and empty=1. A subsequent write of 0x55 followed by a read returns 0x55.
- With SYNC_FIFO_FWFT_EN defined: write 0x33 -> data_out=0x33 on the cycle after the write, before any rd_en. rd_en pops it and empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO (sync_fifo_param) and its
// storage array (fifo_mem_2p).
//   DEF_DATA_WIDTH / DEF_DEPTH : default geometry used by both modules.
//   count_width()              : width of an occupancy counter holding 0..depth.
//   ptr_t                      : pointer index type for the default depth.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    // Occupancy ranges over 0..depth inclusive, so it needs one bit more
    // than the pointer index.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [$clog2(DEF_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array memory with one synchronous write port and one read port.
// Macro SYNC_FIFO_FWFT_EN: when defined the read port is combinational
// (rd_data = mem[rd_addr]); otherwise rd_data is a register loaded on rd_en
// and cleared by reset.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset of the read register (registered mode only)
//   rd_en    : load the read register from mem[rd_addr] (registered mode only)
//   wr_en    : write wr_data into mem[wr_addr]
//   wr_addr  : write index
//   wr_data  : write data
//   rd_addr  : read index
//   rd_data  : read data
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                  rst_n,
    input  logic                  rd_en,
`endif
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem_q[rd_addr];
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Reading and writing the same index on one edge returns the old word,
    // since the array update and this load both see pre-edge contents.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full / almost-empty flags and overflow / underflow pulses.
// Macro SYNC_FIFO_FWFT_EN: when defined, first-word-fall-through (data_out
// shows the head word while non-empty, rd_en pops it); otherwise data_out is
// registered with 1-cycle read latency.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   wr_en        : write request
//   data_in      : write data
//   rd_en        : read request
//   data_out     : read data
//   full         : count == DEPTH
//   empty        : count == 0
//   almost_full  : count >= AFULL_THRESH
//   almost_empty : count <= AEMPTY_THRESH
//   count        : occupancy 0..DEPTH
//   overflow     : one-cycle pulse for a rejected write
//   underflow    : one-cycle pulse for a rejected read
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter  int DEPTH         = DEF_DEPTH,
    localparam int ADDR_WIDTH    = $clog2(DEPTH),
    parameter  int AFULL_THRESH  = DEPTH - 2,
    parameter  int AEMPTY_THRESH = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [count_width(DEPTH)-1:0]   count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int CNT_W = count_width(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Flags decode the registered count directly.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is still taken when a read frees a slot on
    // the same edge; a read of an empty FIFO is never rescued by a write.
    always_comb begin
        rd_acc      = rd_en && !empty;
        wr_acc      = wr_en && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_acc);
        count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        overflow_d  = wr_en && !wr_acc;
        underflow_d = rd_en && !rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst_n   (rst_n),
        .rd_en   (rd_acc),
`endif
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // While empty, the slot at rd_ptr holds stale data, so present the last
    // popped head word instead.
    logic [DATA_WIDTH-1:0] last_head_q, last_head_d;

    always_comb begin
        last_head_d = last_head_q;
        if (rd_acc) begin
            last_head_d = mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_head_q <= '0;
        end else begin
            last_head_q <= last_head_d;
        end
    end

    assign data_out = empty ? last_head_q : mem_rd_data;
`else
    assign data_out = mem_rd_data;
`endif

endmodule
